dcache_line_xfer: RTL and testbench
===================================

// Module: dcache_line_xfer
// PURPOSE
//  Line-transfer engine between the data cache's miss FSM and the backing data memory.
//  On a miss it optionally writes back the dirty victim line, then fills the new line.
//  Both transfers run one word per beat over a single-outstanding req/ack memory port.
//  Returns the filled line to the cache with a one-cycle strobe.
//  Drives BUSY so the pipeline stalls for the whole transfer.
// PARAMETERS
//  WORDS   4   words per cache line; power of 2, >= 2
//  OFF_W   $clog2(WORDS)+2   byte-offset bits in a line; derived, not overridable
// PORTS
//  CLK         in   1         clock; all state on rising edge
//  RST_N       in   1         asynchronous, active-low reset
//  REQ_VALID   in   1         miss request from cache FSM
//  REQ_READY   out  1         engine idle, can accept a request
//  REQ_ADDR    in   32        miss byte address (any offset)
//  WB_NEEDED   in   1         victim line is dirty; write it back before the fill
//  WB_ADDR     in   32        victim byte address (any offset)
//  WB_WORDS    in   32xWORDS  victim line data, unpacked array [WORDS]
//  FILL_WORDS  out  32xWORDS  filled line, unpacked array [WORDS]
//  FILL_VALID  out  1         1-cycle strobe: FILL_WORDS complete
//  BUSY        out  1         stall request to the pipeline
//  MEM_ADDR    out  32        beat word address (byte address, [1:0]=0)
//  MEM_RE      out  1         read beat request
//  MEM_WE      out  1         write beat request
//  MEM_WDATA   out  32        write beat data
//  MEM_RDATA   in   32        read data; valid only with MEM_ACK
//  MEM_ACK     in   1         beat complete (same cycle as request allowed)
// BEHAVIOUR
//  Reset: state IDLE, beat counter 0, FILL_WORDS all 0.
//   MEM_RE, MEM_WE, FILL_VALID and BUSY are 0; REQ_READY is 1; MEM_ADDR and MEM_WDATA are 0.
//  States: IDLE -> (WB ->) FILL -> DONE -> IDLE.
//  IDLE:
//   - REQ_READY=1. The request is accepted on REQ_VALID & REQ_READY.
//   - On accept, latch the line bases {addr[31:OFF_W], OFF_W'b0} of REQ_ADDR and WB_ADDR,
//     latch all WB_WORDS, and clear the counter.
//   - Next state is WB if WB_NEEDED, else FILL.
//  WB:
//   - MEM_WE=1, MEM_ADDR = wb_base | (cnt<<2), MEM_WDATA = wb_words[cnt].
//   - Outputs hold until MEM_ACK; on ACK cnt++.
//   - ACK on the last beat: cnt<=0, go to FILL.
//  FILL:
//   - MEM_RE=1, MEM_ADDR = fill_base | (cnt<<2).
//   - On ACK, FILL_WORDS[cnt] <= MEM_RDATA and cnt++.
//   - ACK on the last beat: go to DONE.
//  DONE: FILL_VALID=1 for exactly one cycle, then IDLE. FILL_WORDS holds until the next fill.
//  MEM_RE and MEM_WE are never both 1. MEM_ACK is ignored while neither is asserted.
//  Beat offsets are ORed into the base, so there is no carry out of the line.
//   Fill order is always word 0..WORDS-1 (no critical-word-first).
//  BUSY = (state != IDLE) | REQ_VALID.
//   The stall therefore starts in the miss cycle itself and drops the cycle after DONE.
//  Latency, with ACK every cycle and accept at cycle 0:
//   - Fill-only: FILL_VALID at cycle WORDS+1.
//   - With write-back: FILL_VALID at cycle 2*WORDS+1.
//   - Each ACK-less cycle adds 1.
//  REQ_VALID while busy is not accepted (REQ_READY=0); the cache FSM holds it.
//  Reset mid-transfer aborts immediately: the memory request drops asynchronously and
//   the partial line is discarded. Re-issuing the miss is the cache FSM's responsibility.
// STRUCTURE
//  Shared package cache_pkg:
//   - WORDS_PER_LINE
//   - typedef logic [31:0] line_t [WORDS_PER_LINE]
//   - typedef enum {IDLE, WB, FILL, DONE} xfer_state_t
//   - The same line_t is used by the cache and data-memory blocks.
//  Single module; no sub-module. The counter and datapath are too small to split.
// TESTING
//  1. Clean miss:
//     REQ_ADDR=0x0000_1234, WB_NEEDED=0, ACK every cycle, RDATA=0xA0+beat
//     -> reads at 0x1230,0x1234,0x1238,0x123C; FILL_VALID at cycle 5;
//        FILL_WORDS={A0,A1,A2,A3}.
//  2. Dirty miss:
//     WB_ADDR=0x0000_0F08, WB_WORDS={1,2,3,4}
//     -> writes 1..4 to 0xF00..0xF0C before any read; FILL_VALID at cycle 9.
//  3. Wait states:
//     ACK only every 3rd cycle
//     -> MEM_ADDR/MEM_WDATA/MEM_RE stable while waiting; no beat skipped or duplicated.
//  4. Line boundary:
//     REQ_ADDR=0x0000_FFFC
//     -> beat addresses 0xFFF0..0xFFFC only, never 0x1_0000.
//  5. Reset mid-fill:
//     drop RST_N after beat 2
//     -> MEM_RE=0 and REQ_READY=1 immediately, FILL_VALID never pulses;
//        the next request completes normally.
//  6. Back-to-back:
//     REQ_VALID held high through DONE
//     -> second accept in the cycle after DONE; BUSY stays 1 throughout.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared data-cache types: line geometry, line container and
// the states of the line-transfer engine.
package cache_pkg;

  localparam int WORDS_PER_LINE = 4;

  typedef logic [31:0] line_t [WORDS_PER_LINE];

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    DONE
  } xfer_state_t;

endpackage

// File: rtl/dcache_line_xfer.sv
// Miss line-transfer engine: optional dirty write-back, then a
// word-by-word fill over a single-outstanding req/ack port.
module dcache_line_xfer
  import cache_pkg::*;
#(
  parameter int WORDS = WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        wb_needed,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_words [WORDS],
  output logic [31:0] fill_words [WORDS],
  output logic        fill_valid,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW    = $clog2(WORDS);
  localparam int OFF_W = CW + 2;

  xfer_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fbase_q, wbase_q;
  logic [31:0]   wbw_q [WORDS];
  logic [31:0]   fw_q  [WORDS];

  logic          accept;
  logic          last;
  logic [31:0]   off;

  function automatic logic [31:0] line_base(
    input logic [31:0] a
  );
    return {a[31:OFF_W], {OFF_W{1'b0}}};
  endfunction

  assign accept     = req_valid & req_ready;
  assign last       = (cnt_q == CW'(WORDS - 1));
  // Offset is ORed into an aligned base, so beats never leave the line
  assign off        = {{(32-OFF_W){1'b0}}, cnt_q, 2'b00};

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE) | req_valid;
  assign fill_valid = (state_q == DONE);
  assign mem_we     = (state_q == WB);
  assign mem_re     = (state_q == FILL);
  assign mem_addr   = mem_we ? (wbase_q | off) :
                      mem_re ? (fbase_q | off) : '0;
  assign mem_wdata  = mem_we ? wbw_q[cnt_q] : '0;
  assign fill_words = fw_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = wb_needed ? WB : FILL;
        end
      end
      WB: begin
        if (mem_ack) begin
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fbase_q <= '0;
      wbase_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        wbw_q[i] <= '0;
        fw_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        fbase_q <= line_base(req_addr);
        wbase_q <= line_base(wb_addr);
        for (int i = 0; i < WORDS; i++) begin
          wbw_q[i] <= wb_words[i];
        end
      end
      if (mem_re && mem_ack) begin
        fw_q[cnt_q] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_line_xfer.sv
// Scoreboard bench for dcache_line_xfer: driver pushes expected
// beats and lines, a negedge monitor pops and compares.
module tb_dcache_line_xfer;
  import cache_pkg::*;

  localparam int W = WORDS_PER_LINE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        wb_needed = 1'b0;
  logic [31:0] wb_addr = '0;
  logic [31:0] wb_words [W];
  logic [31:0] fill_words [W];
  logic        fill_valid;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  dcache_line_xfer #(.WORDS(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .wb_needed  (wb_needed),
    .wb_addr    (wb_addr),
    .wb_words   (wb_words),
    .fill_words (fill_words),
    .fill_valid (fill_valid),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [W-1:0][31:0] w;
    int                 acc;
    int                 lat;
  } line_exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_mode = 0;
  int read_beats = 0;
  int last_fv = -100;

  beat_t     bq[$];
  line_exp_t lq[$];

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory environment: stores acked writes, answers reads
  always begin
    @(posedge clk);
    if (rst_n && mem_we && mem_ack) env_mem[mem_addr] = mem_wdata;
    #1;
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (cyc % 3 == 0);
      default: mem_ack = 1'($urandom_range(0, 1));
    endcase
    mem_rdata = mem_re ? env_rd(mem_addr) : 32'hDEAD_BEEF;
  end

  logic        pend = 1'b0;
  logic [31:0] p_addr, p_wd;
  logic        p_we, p_re;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (mem_re && mem_we) chk("re_we_exclusive", 32'd1, 32'd0);
      if (pend) begin
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_wdata", mem_wdata, p_wd);
        chk("hold_ctl", {30'd0, mem_we, mem_re}, {30'd0, p_we, p_re});
      end
      if ((mem_re || mem_we) && mem_ack) begin
        if (bq.size() == 0) begin
          chk("extra_beat", mem_addr, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = bq.pop_front();
          chk("beat_we", {31'd0, mem_we}, {31'd0, b.we});
          chk("beat_addr", mem_addr, b.addr);
          if (b.we) chk("beat_wdata", mem_wdata, b.data);
        end
        if (mem_re) read_beats++;
      end
      pend = (mem_re || mem_we) && !mem_ack;
      p_addr = mem_addr;
      p_wd = mem_wdata;
      p_we = mem_we;
      p_re = mem_re;
      if (fill_valid) begin
        if (lq.size() == 0) begin
          chk("spurious_fill", 32'd1, 32'd0);
        end else begin
          line_exp_t e;
          e = lq.pop_front();
          chk("beats_before_fill", bq.size(), 0);
          for (int i = 0; i < W; i++) chk("fill_word", fill_words[i], e.w[i]);
          if (e.lat >= 0) chk("fill_latency", cyc - e.acc, e.lat);
        end
        last_fv = cyc;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic wbn,
                       input logic [31:0] wa,
                       input logic [W-1:0][31:0] wd,
                       input bit keep, output int acc);
    line_exp_t   e;
    logic [31:0] fb, wbb;
    int          n;
    req_addr = a;
    wb_needed = wbn;
    wb_addr = wa;
    for (int i = 0; i < W; i++) wb_words[i] = wd[i];
    req_valid = 1'b1;
    n = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      chk("busy_with_req", {31'd0, busy}, 32'd1);
      if (req_ready) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    fb = a & ~32'(4 * W - 1);
    wbb = wa & ~32'(4 * W - 1);
    if (wbn) begin
      for (int i = 0; i < W; i++) begin
        bq.push_back('{1'b1, wbb + 32'(4 * i), wd[i]});
        ref_mem[wbb + 32'(4 * i)] = wd[i];
      end
    end
    for (int i = 0; i < W; i++) begin
      bq.push_back('{1'b0, fb + 32'(4 * i), 32'd0});
      e.w[i] = ref_rd(fb + 32'(4 * i));
    end
    e.acc = cyc;
    e.lat = (ack_mode == 0) ? (wbn ? 2 * W + 1 : W + 1) : -1;
    acc = cyc;
    lq.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (lq.size() != 0 || bq.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        chk("done_timeout", lq.size() + bq.size(), 0);
        lq.delete();
        bq.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0][31:0] wd;
  int acc, acc2, rb0, n;

  initial begin
    for (int i = 0; i < W; i++) wb_words[i] = '0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_fill_valid", {31'd0, fill_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    for (int i = 0; i < W; i++) chk("rst_fill_words", fill_words[i], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: clean miss
    ack_mode = 0;
    for (int i = 0; i < W; i++) begin
      env_mem[32'h1230 + 32'(4 * i)] = 32'hA0 + 32'(i);
      ref_mem[32'h1230 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end
    wd = '0;
    issue(32'h0000_1234, 1'b0, 32'h0, wd, 1'b0, acc);
    wait_done();
    for (int i = 0; i < W; i++) chk("t1_word", fill_words[i], 32'hA0 + 32'(i));

    // 2: dirty miss
    for (int i = 0; i < W; i++) wd[i] = 32'(i + 1);
    issue(32'h0000_2000, 1'b1, 32'h0000_0F08, wd, 1'b0, acc);
    wait_done();
    for (int i = 0; i < W; i++)
      chk("t2_mem", env_rd(32'hF00 + 32'(4 * i)), 32'(i + 1));

    // 3: wait states
    ack_mode = 1;
    for (int i = 0; i < W; i++) wd[i] = $urandom;
    issue(32'h0000_3018, 1'b1, 32'h0000_4024, wd, 1'b0, acc);
    wait_done();

    // 4: line boundary
    ack_mode = 0;
    issue(32'h0000_FFFC, 1'b0, 32'h0, wd, 1'b0, acc);
    wait_done();

    // 5: reset mid-fill
    rb0 = read_beats;
    issue(32'h0000_5000, 1'b0, 32'h0, wd, 1'b0, acc);
    n = 0;
    while (read_beats < rb0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_two_beats", read_beats - rb0, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_re_drop", {31'd0, mem_re}, 32'd0);
    chk("t5_ready", {31'd0, req_ready}, 32'd1);
    lq.delete();
    bq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_fill_valid", {31'd0, fill_valid}, 32'd0);
    for (int i = 0; i < W; i++) chk("t5_fill_clr", fill_words[i], 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'h0000_5004, 1'b1, 32'h0000_6000, wd, 1'b0, acc);
    wait_done();

    // 6: back-to-back with req_valid held
    issue(32'h0000_7000, 1'b1, 32'h0000_7100, wd, 1'b1, acc);
    issue(32'h0000_7200, 1'b0, 32'h0, wd, 1'b0, acc2);
    chk("t6_second_accept", acc2, last_fv + 1);
    wait_done();

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      ack_mode = $urandom_range(0, 2);
      for (int i = 0; i < W; i++) wd[i] = $urandom;
      issue($urandom & 32'h0000_01FF, 1'($urandom_range(0, 1)),
            $urandom & 32'h0000_01FF, wd, 1'b0, acc);
      wait_done();
    end

    chk("queues_empty", lq.size() + bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
